adder_tree_49_fixed_pipelined: RTL and testbench

ADDER_TREE_49_FIXED_PIPELINED -- requirements
Module: adder_tree_49_fixed_pipelined

---
 rtl/adder_tree_49_fixed_pipelined.sv | 103 ++++++++++
 tb/tb_adder_tree_49_fixed_pipelined.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/adder_tree_49_fixed_pipelined.sv
// rtl/adder_tree_49_fixed_pipelined.sv - 49-operand Q16.16 pipelined adder tree, Q22.16 result (optional input register: ADDER_TREE_IN_REG_EN)
module adder_tree_49_fixed_pipelined #(
  parameter int N_IN  = 49,
  parameter int IN_W  = 32,
  parameter int OUT_W = 38
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_IN*IN_W-1:0]   in_flat,
  output logic [OUT_W-1:0]       sum_out
);

  typedef logic signed [OUT_W-1:0] acc_t;

  logic [N_IN*IN_W-1:0] src;
  acc_t                 opnd [N_IN];
  acc_t                 l1 [25];
  acc_t                 l2 [13];
  acc_t                 l3 [7];
  acc_t                 l4 [4];
  acc_t                 l5 [2];
  acc_t                 l6;

`ifdef ADDER_TREE_IN_REG_EN
  logic [N_IN*IN_W-1:0] in_q;

  // Optional input capture stage; adds one enabled edge of latency.
  always_ff @(posedge clk) begin
    if (!rst)    in_q <= '0;
    else if (en) in_q <= in_flat;
  end

  assign src = in_q;
`else
  assign src = in_flat;
`endif

  // Sign-extend every operand to the full result width so no level can overflow.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      opnd[k] = {{(OUT_W-IN_W){src[k*IN_W+IN_W-1]}}, src[k*IN_W +: IN_W]};
    end
  end

  // Level 1: 49 -> 25, operand 48 passes through unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 25; i++) l1[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 24; i++) l1[i] <= opnd[2*i] + opnd[2*i+1];
      l1[24] <= opnd[48];
    end
  end

  // Level 2: 25 -> 13, last entry passes through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 13; i++) l2[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 12; i++) l2[i] <= l1[2*i] + l1[2*i+1];
      l2[12] <= l1[24];
    end
  end

  // Level 3: 13 -> 7, last entry passes through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 7; i++) l3[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 6; i++) l3[i] <= l2[2*i] + l2[2*i+1];
      l3[6] <= l2[12];
    end
  end

  // Level 4: 7 -> 4, last entry passes through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) l4[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) l4[i] <= l3[2*i] + l3[2*i+1];
      l4[3] <= l3[6];
    end
  end

  // Level 5: 4 -> 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) l5[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < 2; i++) l5[i] <= l4[2*i] + l4[2*i+1];
    end
  end

  // Level 6: final sum register, drives the output directly.
  always_ff @(posedge clk) begin
    if (!rst)    l6 <= '0;
    else if (en) l6 <= l5[0] + l5[1];
  end

  assign sum_out = l6;

endmodule

// File: tb/tb_adder_tree_49_fixed_pipelined.sv
// tb/tb_adder_tree_49_fixed_pipelined.sv - directed self-checking bench for adder_tree_49_fixed_pipelined
module tb_adder_tree_49_fixed_pipelined;

`ifdef ADDER_TREE_IN_REG_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [1567:0]      in_flat;
  logic signed [37:0] sum_out;

  int n_tests = 0;
  int n_fail  = 0;

  adder_tree_49_fixed_pipelined dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in_flat (in_flat),
    .sum_out (sum_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < 49; k++) in_flat[k*32 +: 32] = v;
  endtask

  // Hold one vector for LAT edges: output must keep the old result for LAT-1 edges, then show the new one.
  task automatic run_vec(input string tag, input logic signed [63:0] prev, input logic signed [63:0] exp);
    repeat (LAT-1) @(posedge clk);
    @(negedge clk);
    check({tag, "_early"}, sum_out, prev);
    @(posedge clk);
    @(negedge clk);
    check(tag, sum_out, exp);
  endtask

  initial begin
    int ecount;
    int idx;
    logic signed [63:0] exp_v;

    rst = 1'b0;
    en = 1'b0;
    in_flat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", sum_out, 64'sd0);
    rst = 1'b1;
    en = 1'b1;

    set_all(32'h0001_0000);
    run_vec("all_one", 64'sd0, 64'sd3211264);
    @(negedge clk);
    set_all(32'h0000_8000);
    run_vec("all_half", 64'sd3211264, 64'sd1605632);
    @(negedge clk);
    in_flat = '0;
    in_flat[0*32 +: 32] = 32'h0001_0000;
    in_flat[1*32 +: 32] = 32'h0000_8000;
    in_flat[2*32 +: 32] = 32'hFFFF_0000;
    in_flat[3*32 +: 32] = 32'h0001_8000;
    in_flat[4*32 +: 32] = 32'hFFFF_8000;
    run_vec("mixed", 64'sd1605632, 64'sd98304);
    @(negedge clk);
    set_all(32'h8000_0000);
    run_vec("all_min", 64'sd98304, -64'sd105226698752);
    @(negedge clk);
    set_all(32'h7FFF_FFFF);
    run_vec("all_max", -64'sd105226698752, 64'sd105226698703);
    @(negedge clk);
    in_flat = '0;
    in_flat[48*32 +: 32] = 32'h0001_0000;
    run_vec("op48_only", 64'sd105226698703, 64'sd65536);
    @(negedge clk);
    for (int k = 0; k < 49; k++) in_flat[k*32 +: 32] = 32'((k+1)*(k+1));
    run_vec("squares", 64'sd65536, 64'sd40425);

    // Streaming with an en gap: enabled edge m delivers set (m-LAT).
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ecount = 0;
    for (int c = 0; c < 24; c++) begin
      if (c >= 4 && c <= 6) begin
        en = 1'b0;
        set_all(32'h7FFF_FFFF);
      end else begin
        en = 1'b1;
        idx = (c < 4) ? c : c - 3;
        if (idx < 8) set_all(32'(idx + 1));
        else         set_all(32'h0);
      end
      @(posedge clk);
      if (en) ecount++;
      @(negedge clk);
      idx = ecount - LAT;
      exp_v = (idx >= 0 && idx < 8) ? 64'(49 * (idx + 1)) : 64'sd0;
      check($sformatf("stream_c%0d", c), sum_out, exp_v);
    end

    // Mid-operation reset with en low discards everything in flight.
    en = 1'b1;
    set_all(32'h0001_0000);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("pre_rst_full", sum_out, 64'sd3211264);
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst", sum_out, 64'sd0);
    rst = 1'b1;
    en = 1'b1;
    set_all(32'h0000_8000);
    for (int e = 1; e < LAT; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post_rst_e%0d", e), sum_out, 64'sd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("post_rst_result", sum_out, 64'sd1605632);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
